cam_trigger_gen: RTL and testbench
==================================

Name: cam_trigger_gen

Overview:
- Generalised N-camera exposure trigger generator; successor to the fixed two-camera, single-exposure trigger in the ovc2a top level.
- Fires on every (imu_decim+1)-th rising edge of the IMU sync, or from an internal free-running period timer.
- Each channel has its own start delay and exposure length, both in microseconds.
- Latches the 64-bit timestamp at each channel's trigger rising edge; counts sync events lost because channels were still busy.

Parameters:
- N_CAM, 2, number of camera trigger channels.
- TW, 64, timestamp width.
- EW, 16, width of per-channel delay and exposure fields (usec).
- DW, 8, IMU decimation field width.
- PW, 24, free-run period width (usec).
- USEC_DIV, 125, clock cycles per microsecond; sim benches set a small value (e.g. 4).

Ports:
- c  in  1  clock (125 MHz); the block's only clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  enable; low blocks new fires and clears the decimation counter.
- mode  in  1  0 = IMU-locked, 1 = free-run.
- imu_sync  in  1  IMU sync level, already synchronised to c.
- imu_decim  in  DW  fire on every (imu_decim+1)-th sync rising edge.
- period_usec  in  PW  free-run period; 0 disables free-run firing.
- delay_usec  in  N_CAM*EW  per-channel start delay; channel i uses bits [i*EW +: EW].
- exposure_usec  in  N_CAM*EW  per-channel high time; 0 skips that channel.
- t  in  TW  free-running timestamp.
- trigger  out  N_CAM  camera trigger outputs, registered.
- t_trig  out  N_CAM*TW  timestamp latched at each channel's trigger rise.
- t_trig_v  out  N_CAM  one-cycle strobe, t_trig for that channel updated.
- busy  out  1  any channel in DELAY or EXPOSE.
- overrun_cnt  out  16  saturating count of discarded fire requests.

Behaviour:
- Reset (rst_n low, asynchronous): trigger=0, t_trig=0, t_trig_v=0, busy=0, overrun_cnt=0; all channel FSMs go to IDLE; decimation, period and prescaler counters clear.
- Edge detect: sync_d is a register of imu_sync. An edge occurs in cycle k when imu_sync=1 and sync_d=0.
- IMU mode, decimation: on an edge with en=1, request a fire if dcnt==0. Then dcnt <= (dcnt==imu_decim) ? 0 : dcnt+1. The first edge after en rises therefore fires. en=0 holds dcnt at 0.
- Free-run mode: a period counter counts usec ticks. It requests a fire and wraps when it reaches period_usec-1, so fires are exactly period_usec*USEC_DIV cycles apart.
  - period_usec=0 or en=0: counter held at 0, no requests.
  - Entering free-run: the first fire occurs period_usec usec after entry.
- Fire acceptance:
  - A request raised in cycle k is accepted in cycle k+1 (cycle F) only if busy=0.
  - If busy=1 the request is dropped and overrun_cnt increments, saturating at 16'hFFFF.
  - Simultaneous request and last EXPOSE cycle: busy is still 1, so the request counts as an overrun.
- At F:
  - Every channel latches its delay_usec and exposure_usec slice; later input changes have no effect until the next fire.
  - The shared usec prescaler restarts at 0 (tick every USEC_DIV cycles), so all timing is exact in cycles.
- Channel FSM:
  - IDLE --accept, exp>0, dly>0--> DELAY.
  - IDLE --accept, exp>0, dly=0--> EXPOSE.
  - IDLE --accept, exp=0--> stays IDLE (no pulse, no strobe).
  - DELAY --dly*USEC_DIV cycles elapsed--> EXPOSE.
  - EXPOSE --exp*USEC_DIV cycles elapsed--> IDLE.
- trigger[i] timing:
  - trigger[i]=1 exactly while channel i is in EXPOSE.
  - The rise occurs at F+1+dly*USEC_DIV.
  - The high time is exactly exp*USEC_DIV cycles.
- Timestamp capture:
  - t_trig[i] captures the value of t in the cycle trigger[i] rises.
  - t_trig_v[i] pulses for one cycle, in the cycle after the rise.
- busy = OR of all channel states not equal to IDLE, registered. It goes high at F+1 if any channel has exp>0.
- en dropped mid-operation: channels in DELAY/EXPOSE complete normally; no new fires are accepted.
- mode changed mid-operation: channels in progress complete; the counters of the mode being left clear.
- Arithmetic: all counters are unsigned; no wrap is permitted within a pulse. The EW-bit usec count times USEC_DIV is held in a counter wide enough for the full product.

Test Plan:
- USEC_DIV=4, mode 0, imu_decim=0, delay={0,0}, exposure={10,10}: one sync edge -> both triggers high 40 cycles, rising 2 cycles after the edge cycle; t_trig equals t at the rise; t_trig_v pulses once per channel.
- imu_decim=3, 12 sync edges spaced 200 cycles apart: exactly 3 fires, on edges 1, 5 and 9; overrun_cnt=0.
- delay={0,5}, exposure={3,2}: trigger[0] high cycles F+1..F+12; trigger[1] high cycles F+21..F+28; busy falls after F+28.
- exposure={50,50}, sync edges 20 cycles apart: first fire accepted; the next edges arrive while busy, giving overrun_cnt=4 before idle; no re-trigger during the pulse.
- mode 1, period_usec=25, exposure={5,0}: trigger[0] rises every 100 cycles exactly; trigger[1] and t_trig_v[1] stay 0; period_usec=0 -> no fires.
- Assert rst_n low during EXPOSE: trigger, busy and overrun_cnt go to 0 asynchronously, without waiting for a clock edge; after release, the first sync edge fires normally.

Source files
------------

// File: rtl/cam_trigger_gen.sv
// cam_trigger_gen: N-camera exposure trigger generator, IMU-locked or free-run, with timestamp capture and overrun count
module cam_trigger_gen #(
  parameter int N_CAM = 2,
  parameter int TW = 64,
  parameter int EW = 16,
  parameter int DW = 8,
  parameter int PW = 24,
  parameter int USEC_DIV = 125
) (
  input  logic c,
  input  logic rst_n,
  input  logic en,
  input  logic mode,
  input  logic imu_sync,
  input  logic [DW-1:0] imu_decim,
  input  logic [PW-1:0] period_usec,
  input  logic [N_CAM*EW-1:0] delay_usec,
  input  logic [N_CAM*EW-1:0] exposure_usec,
  input  logic [TW-1:0] t,
  output logic [N_CAM-1:0] trigger,
  output logic [N_CAM*TW-1:0] t_trig,
  output logic [N_CAM-1:0] t_trig_v,
  output logic busy,
  output logic [15:0] overrun_cnt
);
  localparam int CW = EW + $clog2(USEC_DIV) + 1;
  localparam int SW = $clog2(USEC_DIV) + 1;
  localparam logic [CW-1:0] DIV_C = CW'(USEC_DIV);
  localparam logic [SW-1:0] DIV_M1 = SW'(USEC_DIV - 1);
  typedef enum logic [1:0] {IDLE = 2'b00, DELAY = 2'b01, EXPOSE = 2'b10} st_e;
  st_e st [N_CAM];
  st_e st_n [N_CAM];
  logic [CW-1:0] cnt [N_CAM];
  logic [CW-1:0] cnt_n [N_CAM];
  logic [EW-1:0] exp_l [N_CAM];
  logic sync_d, req_q, im_act, fr_act, tick, sync_edge, req, busy_n;
  logic [DW-1:0] dcnt;
  logic [PW-1:0] pcnt;
  logic [SW-1:0] fpsc;
  logic [N_CAM-1:0] trig_d;
  assign im_act = en & ~mode;
  assign fr_act = en & mode & (period_usec != '0);
  assign tick = fpsc == DIV_M1;
  assign sync_edge = imu_sync & ~sync_d;
  assign req = (im_act & sync_edge & (dcnt == '0)) | (fr_act & tick & (pcnt >= period_usec - PW'(1)));
  // req_q marks the fire cycle; a request seen while busy (or while a fire is pending) is an overrun
  always_ff @(posedge c or negedge rst_n)
    if (!rst_n) begin
      sync_d <= 1'b0;
      req_q <= 1'b0;
      dcnt <= '0;
      pcnt <= '0;
      fpsc <= '0;
      overrun_cnt <= '0;
    end else begin
      sync_d <= imu_sync;
      req_q <= req & ~busy & ~req_q;
      if (req & (busy | req_q) & ~&overrun_cnt) overrun_cnt <= overrun_cnt + 16'd1;
      if (!im_act) dcnt <= '0;
      else if (sync_edge) dcnt <= (dcnt >= imu_decim) ? '0 : dcnt + DW'(1);
      fpsc <= (!fr_act || tick) ? '0 : fpsc + SW'(1);
      if (!fr_act) pcnt <= '0;
      else if (tick) pcnt <= (pcnt >= period_usec - PW'(1)) ? '0 : pcnt + PW'(1);
    end
  // Per-channel cycle counters load usec*USEC_DIV-1 so phase lengths are exact in clocks
  always_comb begin
    busy_n = 1'b0;
    for (int i = 0; i < N_CAM; i++) begin
      st_n[i] = st[i];
      cnt_n[i] = (cnt[i] == '0) ? cnt[i] : cnt[i] - CW'(1);
      if (st[i] == IDLE && req_q && exposure_usec[i*EW +: EW] != '0) begin
        st_n[i] = (delay_usec[i*EW +: EW] != '0) ? DELAY : EXPOSE;
        cnt_n[i] = ((delay_usec[i*EW +: EW] != '0) ? CW'(delay_usec[i*EW +: EW])
                                                  : CW'(exposure_usec[i*EW +: EW])) * DIV_C - CW'(1);
      end else if (st[i] == DELAY && cnt[i] == '0) begin
        st_n[i] = EXPOSE;
        cnt_n[i] = CW'(exp_l[i]) * DIV_C - CW'(1);
      end else if (st[i] == EXPOSE && cnt[i] == '0) begin
        st_n[i] = IDLE;
      end
      busy_n = busy_n | (st_n[i] != IDLE);
    end
  end
  always_ff @(posedge c or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < N_CAM; i++) begin
        st[i] <= IDLE;
        cnt[i] <= '0;
        exp_l[i] <= '0;
      end
      trigger <= '0;
      trig_d <= '0;
      busy <= 1'b0;
      t_trig <= '0;
      t_trig_v <= '0;
    end else begin
      for (int i = 0; i < N_CAM; i++) begin
        st[i] <= st_n[i];
        cnt[i] <= cnt_n[i];
        trigger[i] <= st_n[i] == EXPOSE;
        if (req_q) exp_l[i] <= exposure_usec[i*EW +: EW];
        if (trigger[i] & ~trig_d[i]) t_trig[i*TW +: TW] <= t;
      end
      trig_d <= trigger;
      busy <= busy_n;
      t_trig_v <= trigger & ~trig_d;
    end
endmodule

// File: tb/tb_cam_trigger_gen.sv
// tb_cam_trigger_gen: vector table, hand sequences and random stimulus checked against a cycle-window model
module tb_cam_trigger_gen;
  localparam int N = 2, TW = 64, EW = 16, DW = 8, PW = 24, D = 4;
  typedef struct {
    int decim; int d0; int d1; int e0; int e1; int n_edges; int gap; int fires; int ovr;
  } vec_t;
  logic c = 1'b0, rst_n = 1'b0, en = 1'b0, mode = 1'b0, imu_sync = 1'b0;
  logic [DW-1:0] imu_decim = '0;
  logic [PW-1:0] period_usec = '0;
  logic [N*EW-1:0] delay_usec = '0, exposure_usec = '0;
  logic [TW-1:0] t = 64'h0123_4567_0000_0000;
  logic [N-1:0] trigger, t_trig_v;
  logic [N*TW-1:0] t_trig;
  logic busy;
  logic [15:0] overrun_cnt;
  int cyc = 0, checks = 0, errors = 0;
  int busy_rises = 0, nrise = 0, rprev = 0, rlast = 0;
  bit busy_q = 0, t0_q = 0;
  int rise [N], fall [N];
  logic [TW-1:0] tt [N];
  int ff = -10, bend = -10, ecnt = 0, fr_start = 0, ov_m = 0;
  bit pend = 0, sync_prev = 0, fr_prev = 0;

  cam_trigger_gen #(.N_CAM(N), .TW(TW), .EW(EW), .DW(DW), .PW(PW), .USEC_DIV(D)) dut (
    .c(c), .rst_n(rst_n), .en(en), .mode(mode), .imu_sync(imu_sync), .imu_decim(imu_decim),
    .period_usec(period_usec), .delay_usec(delay_usec), .exposure_usec(exposure_usec), .t(t),
    .trigger(trigger), .t_trig(t_trig), .t_trig_v(t_trig_v), .busy(busy), .overrun_cnt(overrun_cnt)
  );

  always #5 c = ~c;
  always @(posedge c) begin
    cyc <= cyc + 1;
    t <= t + 64'd3;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, want);
    end
  endtask

  // Reference: each accepted fire at cycle F gives channel i the window [F+1+dly*D, F+(dly+exp)*D]
  always @(negedge c) begin
    int k, e, d;
    bit sedge, req_m, busy_m;
    logic [N-1:0] trig_m, tv_m;
    k = cyc;
    if (!rst_n) begin
      chk("rst_trigger", trigger, 0);
      chk("rst_busy", busy, 0);
      chk("rst_overrun", overrun_cnt, 0);
      chk("rst_tv", t_trig_v, 0);
      pend = 0; ff = -10; bend = -10; ecnt = 0; ov_m = 0; fr_prev = 0;
      for (int i = 0; i < N; i++) begin rise[i] = -10; fall[i] = -10; end
    end else begin
      if (pend) begin
        pend = 0;
        ff = k;
        for (int i = 0; i < N; i++) begin
          d = int'(delay_usec[i*EW +: EW]);
          e = int'(exposure_usec[i*EW +: EW]);
          if (e > 0) begin
            rise[i] = k + 1 + d * D;
            fall[i] = k + (d + e) * D;
            if (fall[i] > bend) bend = fall[i];
          end
        end
      end
      busy_m = k > ff && k <= bend;
      for (int i = 0; i < N; i++) begin
        trig_m[i] = k >= rise[i] && k <= fall[i];
        tv_m[i] = k == rise[i] + 1;
      end
      chk("trigger", trigger, trig_m);
      chk("busy", busy, busy_m);
      chk("t_trig_v", t_trig_v, tv_m);
      chk("overrun_cnt", overrun_cnt, ov_m);
      for (int i = 0; i < N; i++) begin
        if (k == rise[i] + 1) chk($sformatf("t_trig%0d", i), t_trig[i*TW +: TW], tt[i]);
        if (k == rise[i]) tt[i] = t;
      end
      sedge = imu_sync && !sync_prev;
      req_m = 0;
      if (!(en && !mode)) ecnt = 0;
      else if (sedge) begin
        req_m = (ecnt % (int'(imu_decim) + 1)) == 0;
        ecnt++;
      end
      if (en && mode && period_usec != 0) begin
        if (!fr_prev) fr_start = k;
        if ((k - fr_start + 1) % (int'(period_usec) * D) == 0) req_m = 1;
        fr_prev = 1;
      end else fr_prev = 0;
      if (req_m) begin
        if (busy_m || pend || k == ff) ov_m = (ov_m < 65535) ? ov_m + 1 : ov_m;
        else pend = 1;
      end
    end
    sync_prev = rst_n && imu_sync;
  end

  always @(negedge c) begin
    if (busy && !busy_q) busy_rises++;
    if (trigger[0] && !t0_q) begin nrise++; rprev = rlast; rlast = cyc; end
    busy_q = busy;
    t0_q = trigger[0];
  end

  task automatic pulse(input int gap);
    @(posedge c); #1 imu_sync = 1'b1;
    repeat (2) @(posedge c);
    #1 imu_sync = 1'b0;
    repeat (gap - 3) @(posedge c);
  endtask

  task automatic wait_idle;
    int n;
    n = 0;
    @(negedge c);
    while (busy && n < 5000) begin @(negedge c); n++; end
    chk("idle_wait", busy, 1'b0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    @(posedge c); #1;
    rst_n = 1'b0; en = 1'b0; mode = 1'b0;
    imu_decim = DW'(v.decim);
    delay_usec = {16'(v.d1), 16'(v.d0)};
    exposure_usec = {16'(v.e1), 16'(v.e0)};
    @(posedge c); #1;
    rst_n = 1'b1; en = 1'b1; busy_rises = 0;
    for (int n = 0; n < v.n_edges; n++) pulse(v.gap);
    wait_idle();
    chk($sformatf("vec%0d_fires", idx), busy_rises, v.fires);
    chk($sformatf("vec%0d_overrun", idx), overrun_cnt, v.ovr);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl [6];
    logic [TW-1:0] tr;
    tbl[0] = '{0, 0, 0, 10, 10, 1, 200, 1, 0};
    tbl[1] = '{3, 0, 0, 10, 10, 12, 200, 3, 0};
    tbl[2] = '{0, 0, 5, 3, 2, 1, 100, 1, 0};
    tbl[3] = '{0, 0, 0, 50, 50, 5, 20, 1, 4};
    tbl[4] = '{1, 2, 0, 0, 3, 4, 100, 2, 0};
    tbl[5] = '{0, 1, 1, 0, 0, 2, 50, 0, 0};
    repeat (3) @(posedge c);
    #1;
    chk("reset_trigger", trigger, 0);
    chk("reset_busy", busy, 0);
    chk("reset_overrun", overrun_cnt, 0);
    chk("reset_t_trig0", t_trig[TW-1:0], 0);
    chk("reset_t_trig1", t_trig[2*TW-1:TW], 0);
    chk("reset_tv", t_trig_v, 0);
    rst_n = 1'b1; en = 1'b1;
    exposure_usec = {16'd10, 16'd10};
    repeat (5) @(posedge c);
    #1 imu_sync = 1'b1;
    @(posedge c); #1 imu_sync = 1'b0;
    for (int j = 1; j <= 43; j++) begin
      @(negedge c);
      if (j == 1) chk("tp1_pre", trigger, 2'b00);
      if (j == 2) begin chk("tp1_rise", trigger, 2'b11); chk("tp1_busy", busy, 1'b1); tr = t; end
      if (j == 3) begin
        chk("tp1_tv", t_trig_v, 2'b11);
        chk("tp1_tt0", t_trig[TW-1:0], tr);
        chk("tp1_tt1", t_trig[2*TW-1:TW], tr);
      end
      if (j == 4) chk("tp1_tv_once", t_trig_v, 2'b00);
      if (j == 41) chk("tp1_last", trigger, 2'b11);
      if (j == 42) begin chk("tp1_fall", trigger, 2'b00); chk("tp1_idle", busy, 1'b0); end
    end
    for (int i = 0; i < 6; i++) run_vec(tbl[i], i);
    @(posedge c); #1;
    mode = 1'b1; period_usec = 24'd25; delay_usec = '0; exposure_usec = {16'd0, 16'd5};
    nrise = 0;
    repeat (420) @(posedge c);
    #1;
    chk("fr_nrise", nrise, 4);
    chk("fr_gap", rlast - rprev, 100);
    period_usec = '0; busy_rises = 0;
    repeat (300) @(posedge c);
    #1;
    chk("fr_off_fires", busy_rises, 0);
    mode = 1'b0; imu_decim = '0; exposure_usec = {16'd50, 16'd50};
    pulse(20);
    pulse(20);
    @(negedge c);
    chk("pre_rst_overrun", overrun_cnt, 1);
    chk("pre_rst_trigger", trigger, 2'b11);
    #2 rst_n = 1'b0;
    #1;
    chk("async_trigger", trigger, 0);
    chk("async_busy", busy, 0);
    chk("async_overrun", overrun_cnt, 0);
    repeat (2) @(posedge c);
    #1 rst_n = 1'b1;
    pulse(60);
    @(negedge c);
    chk("post_rst_trigger", trigger, 2'b11);
    wait_idle();
    for (int it = 0; it < 20; it++) begin
      @(posedge c); #1;
      en = 1'b0;
      delay_usec = {16'($urandom_range(0, 6)), 16'($urandom_range(0, 6))};
      exposure_usec = {16'($urandom_range(0, 8)), 16'($urandom_range(0, 8))};
      imu_decim = DW'($urandom_range(0, 2));
      @(posedge c); #1 en = 1'b1;
      if ($urandom_range(0, 3) == 0) begin
        mode = 1'b1;
        period_usec = PW'($urandom_range(1, 12));
        repeat (300) @(posedge c);
        #1 period_usec = '0; mode = 1'b0;
      end else begin
        for (int n = 0; n < int'($urandom_range(1, 5)); n++) pulse(int'($urandom_range(5, 120)));
      end
    end
    wait_idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
